// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one physical-memory line port between the I-cache and
// D-cache miss paths, with one outstanding pmem transaction at a time.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie-break between I and D).
// Without it, D always beats I on a tie.
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [2:0] {StIdle, StServeI, StServeD, StRespI, StRespD} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_line;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic                r_i_resp;
  logic                r_d_resp;

  logic                w_d_req;
  logic                w_grant_d;

  assign w_d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = I was granted last; reset value makes D win the first tie.
  logic r_last_grant_i;

  assign w_grant_d = w_d_req & (~i_read | r_last_grant_i);

  // Track the most recent winner so the other side wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant_i <= 1'b1;
    end else if (r_state == StIdle && (w_d_req || i_read)) begin
      r_last_grant_i <= ~w_grant_d;
    end
  end
`else
  assign w_grant_d = w_d_req;
`endif

  // Main sequencer: grant in idle, hold pmem strobe until pmem_resp, pulse resp once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_line       <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_d) begin
            r_state      <= StServeD;
            r_addr       <= d_address;
            r_wdata      <= d_wdata;
            // A write wins over a simultaneous read.
            r_pmem_write <= d_write;
            r_pmem_read  <= ~d_write;
          end else if (i_read) begin
            r_state     <= StServeI;
            r_addr      <= i_address;
            r_pmem_read <= 1'b1;
          end
        end
        StServeI: begin
          if (pmem_resp) begin
            r_line       <= pmem_rdata;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_i_resp     <= 1'b1;
            r_state      <= StRespI;
          end
        end
        StServeD: begin
          if (pmem_resp) begin
            r_line       <= pmem_rdata;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_d_resp     <= 1'b1;
            r_state      <= StRespD;
          end
        end
        StRespI, StRespD: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign i_rdata      = r_line;
  assign d_rdata      = r_line;
  assign i_resp       = r_i_resp;
  assign d_resp       = r_d_resp;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: random requesters and a pmem responder, with expected pmem
// transactions and cache responses queued by a transaction-level arbitration model.
module tb_cache_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit abort  = 1'b0;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
  } pm_t;

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [LW-1:0] rdata;
  } rs_t;

  pm_t pm_q[$];
  rs_t rs_q[$];

  // Reference model state: who is owed service, what they asked for, last winner.
  bit            i_pend = 1'b0;
  bit            d_pend = 1'b0;
  bit            dwr    = 1'b0;
  logic [AW-1:0] ia     = '0;
  logic [AW-1:0] da     = '0;
  logic [LW-1:0] dwd    = '0;
  bit            last_i = 1'b1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_i();
    ia        = AW'($urandom()) & 16'hFFF0;
    i_address = ia;
    i_read    = 1'b1;
    i_pend    = 1'b1;
  endtask

  task automatic set_d();
    logic [1:0] op;
    op        = 2'($urandom_range(1, 3));
    da        = AW'($urandom()) & 16'hFFF0;
    dwd       = rand_line();
    dwr       = op[1];
    d_address = da;
    d_wdata   = dwd;
    d_read    = op[0];
    d_write   = op[1];
    d_pend    = 1'b1;
  endtask

  // Decide the winner among pending requesters and queue the expected traffic.
  task automatic issue(output bit gd);
    pm_t p;
    rs_t r;
    bit  dwin;
`ifdef ARB_ROUND_ROBIN_EN
    dwin = d_pend && (!i_pend || last_i);
`else
    dwin = d_pend;
`endif
    last_i  = !dwin;
    p.wr    = dwin && dwr;
    p.addr  = dwin ? da : ia;
    p.wdata = dwd;
    p.rdata = rand_line();
    p.lat   = $urandom_range(1, 4);
    pm_q.push_back(p);
    r.is_d  = dwin;
    r.wr    = p.wr;
    r.rdata = p.rdata;
    rs_q.push_back(r);
    gd = dwin;
  endtask

  task automatic run_one(input bit allow_new);
    bit         gd;
    bit         seen;
    int         t;
    logic [1:0] who;
    if (!i_pend && !d_pend) begin
      if (!allow_new) return;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      who = 2'($urandom_range(1, 3));
      if (who[0]) set_i();
      if (who[1]) set_d();
    end
    issue(gd);
    seen = 1'b0;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (i_resp || d_resp) break;
      if (!seen && (pmem_read || pmem_write)) begin
        // Winner is being served: its inputs must now be ignored.
        seen = 1'b1;
        if (gd) begin
          d_address = AW'($urandom());
          d_wdata   = rand_line();
          if ($urandom_range(0, 3) == 0) begin
            d_read  = 1'b0;
            d_write = 1'b0;
          end
        end else begin
          i_address = AW'($urandom());
          if ($urandom_range(0, 3) == 0) i_read = 1'b0;
        end
      end
    end
    chk("resp_in_time", LW'(t < 200), LW'(1));
    if (t >= 200) begin
      abort = 1'b1;
      return;
    end
    if (gd) begin
      d_pend  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      if (allow_new && $urandom_range(0, 1) == 1) set_d();
    end else begin
      i_pend = 1'b0;
      i_read = 1'b0;
      if (allow_new && $urandom_range(0, 1) == 1) set_i();
    end
    if (allow_new && !i_pend && $urandom_range(0, 2) == 0) set_i();
    if (allow_new && !d_pend && $urandom_range(0, 2) == 0) set_d();
  endtask

  // pmem responder: checks each transaction against the queue, replies after its latency.
  initial begin
    bit  busy = 1'b0;
    bit  real_resp = 1'b0;
    int  cnt = 0;
    pm_t cur;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy      = 1'b0;
        pmem_resp = 1'b0;
        real_resp = 1'b0;
      end else begin
        if (pmem_resp) begin
          pmem_resp = 1'b0;
          if (real_resp) begin
            chk("strobe_drop", LW'({pmem_read, pmem_write}), LW'(0));
            busy      = 1'b0;
            real_resp = 1'b0;
          end
        end
        if (!busy && !pmem_resp && (pmem_read || pmem_write)) begin
          if (pm_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pmem_unexpected: got addr %h expected no transaction", pmem_address);
          end else begin
            cur = pm_q.pop_front();
            chk("pmem_op", LW'({pmem_read, pmem_write}), LW'({!cur.wr, cur.wr}));
            chk("pmem_addr", LW'(pmem_address), LW'(cur.addr));
            if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
            busy = 1'b1;
            cnt  = cur.lat;
          end
        end else if (busy && !pmem_resp) begin
          chk("pmem_hold_op", LW'({pmem_read, pmem_write}), LW'({!cur.wr, cur.wr}));
          chk("pmem_hold_addr", LW'(pmem_address), LW'(cur.addr));
        end else if (!busy && !pmem_resp && $urandom_range(0, 5) == 0) begin
          // Stray completion while nothing is in flight.
          pmem_rdata = rand_line();
          pmem_resp  = 1'b1;
          real_resp  = 1'b0;
        end
        if (busy && !pmem_resp) begin
          cnt--;
          if (cnt == 0) begin
            pmem_rdata = cur.rdata;
            pmem_resp  = 1'b1;
            real_resp  = 1'b1;
          end
        end
      end
    end
  end

  // Response monitor: every resp pulse must match the head of the expected queue.
  initial begin
    bit  prev = 1'b0;
    rs_t e;
    forever begin
      @(negedge clk);
      if (!rst && (i_resp || d_resp)) begin
        chk("resp_onehot", LW'(i_resp & d_resp), LW'(0));
        chk("resp_single_cycle", LW'(prev), LW'(0));
        if (rs_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
        end else begin
          e = rs_q.pop_front();
          chk("resp_who", LW'({i_resp, d_resp}), LW'({!e.is_d, e.is_d}));
          if (!e.wr) chk("resp_data", e.is_d ? d_rdata : i_rdata, e.rdata);
        end
      end
      prev = !rst && (i_resp || d_resp);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp"}, LW'({i_resp, d_resp}), LW'(0));
    chk({tag, "_strobe"}, LW'({pmem_read, pmem_write}), LW'(0));
    chk({tag, "_addr"}, LW'(pmem_address), LW'(0));
    chk({tag, "_wdata"}, pmem_wdata, LW'(0));
    chk({tag, "_i_rdata"}, i_rdata, LW'(0));
    chk({tag, "_d_rdata"}, d_rdata, LW'(0));
  endtask

  initial begin
    pm_t p;
    int  t;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int n = 0; n < 40 && !abort; n++) run_one(1'b1);
    for (int n = 0; n < 3 && !abort; n++) run_one(1'b0);

    if (!abort) begin
      // Reset while serving a D read; a pending I read must then be served normally.
      repeat (2) @(negedge clk);
      da        = 16'h5670;
      d_address = da;
      d_read    = 1'b1;
      d_write   = 1'b0;
      p.wr      = 1'b0;
      p.addr    = da;
      p.wdata   = '0;
      p.rdata   = rand_line();
      p.lat     = 20;
      pm_q.push_back(p);
      for (t = 0; t < 20; t++) begin
        @(negedge clk);
        if (pmem_read) break;
      end
      chk("rst_serve_d_strobe", LW'(pmem_read), LW'(1));
      set_i();
      rst = 1'b1;
      #1;
      chk_all_zero("mid_reset");
      d_read = 1'b0;
      d_pend = 1'b0;
      last_i = 1'b1;
      @(negedge clk);
      pm_q.delete();
      rs_q.delete();
      @(negedge clk);
      rst = 1'b0;
      run_one(1'b0);
    end

    repeat (5) @(negedge clk);
    chk("pm_q_drained", LW'(pm_q.size()), LW'(0));
    chk("rs_q_drained", LW'(rs_q.size()), LW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1);
  end

endmodule
